// File: rtl/bank_arb_pkg.sv
// Shared types and constants for the two-port bank request arbiter.
// The grant encoding, the conflict counter width and the round-robin helper live here.
package bank_arb_pkg;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  localparam int CONFLICT_CNT_W = 16;

  // Round-robin: a conflict goes to the port that did not win the previous conflict.
  function automatic grant_t other_port(input grant_t last);
    return (last == GRANT_A) ? GRANT_B : GRANT_A;
  endfunction

endpackage

// File: rtl/bank_request_arbiter_if.sv
// Request, memory and read-return signals between two requesters, the arbiter and a dual-port memory.
// The master side holds the requesters and the memory. The slave side is the arbiter.
interface bank_request_arbiter_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_TOTAL = 5
);
  import bank_arb_pkg::*;

  // Requester side
  logic                  i_valid_a,  i_valid_b;
  logic                  o_ready_a,  o_ready_b;
  logic                  i_we_a,     i_we_b;
  logic [ADDR_TOTAL-1:0] i_addr_a,   i_addr_b;
  logic [WIDTH-1:0]      i_wdata_a,  i_wdata_b;

  // Memory side
  logic                  o_mem_en_a,   o_mem_en_b;
  logic                  o_mem_we_a,   o_mem_we_b;
  logic [ADDR_TOTAL-1:0] o_mem_addr_a, o_mem_addr_b;
  logic [WIDTH-1:0]      o_mem_din_a,  o_mem_din_b;
  logic [WIDTH-1:0]      i_mem_dout_a, i_mem_dout_b;

  // Read return and status
  logic                      o_rvalid_a, o_rvalid_b;
  logic [WIDTH-1:0]          o_rdata_a,  o_rdata_b;
  logic [CONFLICT_CNT_W-1:0] o_conflict_cnt;

  modport master (
    output i_valid_a, i_valid_b, i_we_a, i_we_b,
    output i_addr_a, i_addr_b, i_wdata_a, i_wdata_b,
    output i_mem_dout_a, i_mem_dout_b,
    input  o_ready_a, o_ready_b,
    input  o_mem_en_a, o_mem_en_b, o_mem_we_a, o_mem_we_b,
    input  o_mem_addr_a, o_mem_addr_b, o_mem_din_a, o_mem_din_b,
    input  o_rvalid_a, o_rvalid_b, o_rdata_a, o_rdata_b,
    input  o_conflict_cnt
  );

  modport slave (
    input  i_valid_a, i_valid_b, i_we_a, i_we_b,
    input  i_addr_a, i_addr_b, i_wdata_a, i_wdata_b,
    input  i_mem_dout_a, i_mem_dout_b,
    output o_ready_a, o_ready_b,
    output o_mem_en_a, o_mem_en_b, o_mem_we_a, o_mem_we_b,
    output o_mem_addr_a, o_mem_addr_b, o_mem_din_a, o_mem_din_b,
    output o_rvalid_a, o_rvalid_b, o_rdata_a, o_rdata_b,
    output o_conflict_cnt
  );

endinterface

// File: rtl/read_valid_pipe.sv
// Shift register of DEPTH stages.
// It marks the cycle in which the memory's read data for an accepted read becomes valid.
module read_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  output logic o_valid
);

  logic [DEPTH-1:0] stage;

  // NOTE: sequential state uses non-blocking assignments, so every stage samples the pre-edge value of its predecessor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign o_valid = stage[DEPTH-1];

endmodule

// File: rtl/bank_request_arbiter.sv
// Arbitrates two requesters onto the two ports of a multi-bank dual-port memory.
// Same-bank collisions are resolved round-robin. Read-valid is tracked READ_LAT cycles deep per port.
module bank_request_arbiter
  import bank_arb_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_TOTAL = 5,
  parameter int NUM_BANK   = 4,
  parameter int READ_LAT   = 1
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  bank_request_arbiter_if.slave bus
);

  localparam int BANK_W = $clog2(NUM_BANK);

  logic [BANK_W-1:0]         bank_a, bank_b;
  logic                      conflict;
  grant_t                    last_grant, grant;
  logic                      ready_a, ready_b;
  logic                      accept_a, accept_b;
  logic                      rvalid_a, rvalid_b;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt;

  // The top address bits select the bank. Each bank is one contiguous block of addresses.
  assign bank_a = bus.i_addr_a[ADDR_TOTAL-1 -: BANK_W];
  assign bank_b = bus.i_addr_b[ADDR_TOTAL-1 -: BANK_W];

  // NOTE: every always_comb output gets a default first, so no path through the block can infer a latch.
  always_comb begin
    conflict = 1'b0;
    grant    = other_port(last_grant);
    ready_a  = 1'b0;
    ready_b  = 1'b0;
    if (i_rst_n) begin
      conflict = bus.i_valid_a & bus.i_valid_b & (bank_a == bank_b);
      ready_a  = ~conflict | (grant == GRANT_A);
      ready_b  = ~conflict | (grant == GRANT_B);
    end
  end

  assign accept_a = bus.i_valid_a & ready_a;
  assign accept_b = bus.i_valid_b & ready_b;

  // Without a conflict, ready is high whether or not valid is. The loser of a conflict keeps its request held.
  assign bus.o_ready_a = ready_a;
  assign bus.o_ready_b = ready_b;

  assign bus.o_mem_en_a   = accept_a;
  assign bus.o_mem_en_b   = accept_b;
  assign bus.o_mem_we_a   = accept_a & bus.i_we_a;
  assign bus.o_mem_we_b   = accept_b & bus.i_we_b;
  assign bus.o_mem_addr_a = bus.i_addr_a;
  assign bus.o_mem_addr_b = bus.i_addr_b;
  assign bus.o_mem_din_a  = bus.i_wdata_a;
  assign bus.o_mem_din_b  = bus.i_wdata_b;

  // Reset presets the pointer to B, so port A wins the first conflict.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant <= GRANT_B;
    end else if (conflict) begin
      last_grant <= grant;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  assign bus.o_conflict_cnt = conflict_cnt;

  read_valid_pipe #(.DEPTH(READ_LAT)) u_rvalid_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (accept_a & ~bus.i_we_a),
    .o_valid (rvalid_a)
  );

  read_valid_pipe #(.DEPTH(READ_LAT)) u_rvalid_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (accept_b & ~bus.i_we_b),
    .o_valid (rvalid_b)
  );

  // NOTE: read data is never stored here; it is gated from the memory output, so only the valid bits need a reset.
  assign bus.o_rvalid_a = rvalid_a;
  assign bus.o_rvalid_b = rvalid_b;
  assign bus.o_rdata_a  = rvalid_a ? bus.i_mem_dout_a : '0;
  assign bus.o_rdata_b  = rvalid_b ? bus.i_mem_dout_b : '0;

endmodule

// File: tb/tb_bank_request_arbiter.sv
// Scoreboard bench for bank_request_arbiter, wired to a behavioural one-cycle-latency dual-port RAM.
// Directed scenarios are followed by random traffic and a long run of conflicts that saturates the counter.
module tb_bank_request_arbiter;

  localparam int WIDTH      = 8;
  localparam int ADDR_TOTAL = 5;
  localparam int NUM_BANK   = 4;
  localparam int READ_LAT   = 1;
  localparam int DEPTH      = 1 << ADDR_TOTAL;
  localparam int BANK_SIZE  = DEPTH / NUM_BANK;

  logic i_clk;
  logic i_rst_n;

  bank_request_arbiter_if #(.WIDTH(WIDTH), .ADDR_TOTAL(ADDR_TOTAL)) bus ();

  bank_request_arbiter #(
    .WIDTH(WIDTH), .ADDR_TOTAL(ADDR_TOTAL), .NUM_BANK(NUM_BANK), .READ_LAT(READ_LAT)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Stand-in for the dual-port memory: synchronous write, registered read with one cycle of latency.
  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge i_clk) begin
    if (bus.o_mem_en_a) begin
      if (bus.o_mem_we_a) ram[bus.o_mem_addr_a] <= bus.o_mem_din_a;
      else                bus.i_mem_dout_a      <= ram[bus.o_mem_addr_a];
    end
    if (bus.o_mem_en_b) begin
      if (bus.o_mem_we_b) ram[bus.o_mem_addr_b] <= bus.o_mem_din_b;
      else                bus.i_mem_dout_b      <= ram[bus.o_mem_addr_b];
    end
  end

  // Reference model state and the expectations for the current cycle
  typedef struct {
    int               due;
    logic [WIDTH-1:0] data;
  } rd_exp_t;

  rd_exp_t          q_a[$];
  rd_exp_t          q_b[$];
  logic [WIDTH-1:0] mdl_mem [DEPTH];
  bit               mdl_a_won_last;
  int               mdl_cnt;

  int               cyc;
  int               checks;
  int               failures;
  bit               exp_ra, exp_rb, exp_ena, exp_enb, exp_wea, exp_web;
  logic [ADDR_TOTAL-1:0] exp_aa, exp_ab;
  logic [WIDTH-1:0]      exp_da, exp_db;
  int               exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  // Drives one cycle of stimulus and advances the reference model accordingly.
  task automatic step(input bit rst, input bit va, input bit wa, input int aa, input int da,
                      input bit vb, input bit wb, input int ab, input int db);
    bit same, acc_a, acc_b;
    @(posedge i_clk);
    #1;
    cyc++;
    i_rst_n       = rst;
    bus.i_valid_a = va;  bus.i_we_a = wa;
    bus.i_addr_a  = ADDR_TOTAL'(aa);  bus.i_wdata_a = WIDTH'(da);
    bus.i_valid_b = vb;  bus.i_we_b = wb;
    bus.i_addr_b  = ADDR_TOTAL'(ab);  bus.i_wdata_b = WIDTH'(db);

    if (!rst) begin
      q_a.delete();
      q_b.delete();
      mdl_cnt        = 0;
      mdl_a_won_last = 1'b0;
    end
    exp_cnt = mdl_cnt;
    exp_ra  = rst;
    exp_rb  = rst;
    if (rst) begin
      same = va && vb && ((aa / BANK_SIZE) == (ab / BANK_SIZE));
      if (same) begin
        exp_ra         = !mdl_a_won_last;
        exp_rb         = mdl_a_won_last;
        mdl_a_won_last = !mdl_a_won_last;
        mdl_cnt        = (mdl_cnt >= 65535) ? 65535 : mdl_cnt + 1;
      end
    end
    acc_a   = va && exp_ra;
    acc_b   = vb && exp_rb;
    exp_ena = acc_a;
    exp_enb = acc_b;
    exp_wea = acc_a && wa;
    exp_web = acc_b && wb;
    exp_aa  = ADDR_TOTAL'(aa);
    exp_ab  = ADDR_TOTAL'(ab);
    exp_da  = WIDTH'(da);
    exp_db  = WIDTH'(db);
    if (acc_a && !wa) q_a.push_back('{cyc + READ_LAT, mdl_mem[aa]});
    if (acc_b && !wb) q_b.push_back('{cyc + READ_LAT, mdl_mem[ab]});
    if (acc_a && wa) mdl_mem[aa] = WIDTH'(da);
    if (acc_b && wb) mdl_mem[ab] = WIDTH'(db);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every DUT output on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge i_clk);
      if (cyc > 0) begin
        check("ready_a", bus.o_ready_a, exp_ra);
        check("ready_b", bus.o_ready_b, exp_rb);
        check("mem_en_a", bus.o_mem_en_a, exp_ena);
        check("mem_en_b", bus.o_mem_en_b, exp_enb);
        check("mem_we_a", bus.o_mem_we_a, exp_wea);
        check("mem_we_b", bus.o_mem_we_b, exp_web);
        check("mem_addr_a", bus.o_mem_addr_a, exp_aa);
        check("mem_addr_b", bus.o_mem_addr_b, exp_ab);
        check("mem_din_a", bus.o_mem_din_a, exp_da);
        check("mem_din_b", bus.o_mem_din_b, exp_db);
        check("conflict_cnt", bus.o_conflict_cnt, exp_cnt);
        if (q_a.size() > 0 && q_a[0].due == cyc) begin
          check("rvalid_a", bus.o_rvalid_a, 1);
          check("rdata_a", bus.o_rdata_a, q_a[0].data);
          void'(q_a.pop_front());
        end else begin
          check("rvalid_a_idle", bus.o_rvalid_a, 0);
          check("rdata_a_idle", bus.o_rdata_a, 0);
        end
        if (q_b.size() > 0 && q_b[0].due == cyc) begin
          check("rvalid_b", bus.o_rvalid_b, 1);
          check("rdata_b", bus.o_rdata_b, q_b[0].data);
          void'(q_b.pop_front());
        end else begin
          check("rvalid_b_idle", bus.o_rvalid_b, 0);
          check("rdata_b_idle", bus.o_rdata_b, 0);
        end
      end
    end
  end

  initial begin
    int a, b;
    cyc = 0; checks = 0; failures = 0;
    mdl_cnt = 0; mdl_a_won_last = 1'b0;
    i_rst_n = 1'b0;
    bus.i_valid_a = 0; bus.i_we_a = 0; bus.i_addr_a = '0; bus.i_wdata_a = '0;
    bus.i_valid_b = 0; bus.i_we_b = 0; bus.i_addr_b = '0; bus.i_wdata_b = '0;

    // Held in reset while requesting: nothing may be accepted.
    for (int i = 0; i < 3; i++)
      step(0, 1, $urandom_range(1), $urandom_range(31), $urandom_range(255),
              1, $urandom_range(1), $urandom_range(31), $urandom_range(255));

    // Preload: A fills banks 0-1, B fills banks 2-3 with no conflicts.
    for (int i = 0; i < DEPTH / 2; i++)
      step(1, 1, 1, i, $urandom_range(255), 1, 1, i + DEPTH / 2, $urandom_range(255));

    // A writes, B reads, in different banks.
    step(1, 1, 1, 'h03, 'h5A, 1, 0, 'h1B, 0);
    idle(1);

    // First conflict: A wins; B holds and is taken next cycle.
    step(1, 1, 0, 'h08, 0, 1, 0, 'h0C, 0);
    step(1, 0, 0, 0, 0, 1, 0, 'h0C, 0);
    idle(2);

    // Restart, then four conflicting cycles on bank 2 alternate A, B, A, B.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 'h10 + i, 0, 1, 0, 'h14 + i, 0);
    idle(2);

    // Back-to-back: write 0x00..0x07, then read them on consecutive cycles.
    for (int i = 0; i < 8; i++) step(1, 1, 1, i, 'hC0 + i * 3, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, i, 0, 0, 0, 0, 0);
    idle(2);

    // Reset in the cycle after an accepted read drops it.
    step(1, 1, 0, 'h05, 0, 0, 0, 0, 0);
    step(0, 1, 0, 'h06, 0, 1, 0, 'h07, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Same-bank write on A against a read on B, in both grant orders.
    step(1, 1, 1, 'h09, 'h77, 1, 0, 'h09, 0);
    step(1, 0, 0, 0, 0, 1, 0, 'h09, 0);
    step(1, 1, 1, 'h0A, 'h66, 1, 0, 'h0A, 0);
    step(1, 1, 1, 'h0A, 'h66, 0, 0, 0, 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      step(1, $urandom_range(1), $urandom_range(1), $urandom_range(31), $urandom_range(255),
              $urandom_range(1), $urandom_range(1), $urandom_range(31), $urandom_range(255));
    idle(2);

    // Counter saturation: 65540 conflict cycles.
    for (int i = 0; i < 65540; i++) begin
      a = $urandom_range(31);
      b = (a / BANK_SIZE) * BANK_SIZE + $urandom_range(BANK_SIZE - 1);
      step(1, 1, $urandom_range(1), a, $urandom_range(255), 1, $urandom_range(1), b, $urandom_range(255));
    end
    idle(3);
    @(negedge i_clk);
    #1;
    check("cnt_saturated", bus.o_conflict_cnt, 'hFFFF);
    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
